// File: rtl/dma_types.sv
// Shared types and constants for the OAM DMA feeder and the bus arbiter.
package dma_types;

   typedef enum logic [1:0] {IDLE, START, XFER} dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   // Used by the bus arbiter to map OAM writes.
   localparam logic [15:0] OAM_BASE     = 16'hFE00;

   // Pages 0xE0-0xFF are echo RAM and alias WRAM at 0xC0-0xDF.
   localparam logic [7:0]  ECHO_PAGE_LO   = 8'hE0;
   localparam logic [7:0]  ECHO_PAGE_MASK = 8'hDF;

   function automatic logic [7:0] eff_page(input logic [7:0] page);
      return (page >= ECHO_PAGE_LO) ? (page & ECHO_PAGE_MASK) : page;
   endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA: copies OAM_BYTES bytes from {page, 8'h00} into OAM after a write
// to 0xFF46, one byte every CYCLES_PER_BYTE clocks.
module oam_dma
   import dma_types::*;
#(
   parameter int unsigned CYCLES_PER_BYTE = 4,  // >= 3
   parameter int unsigned START_DELAY     = 4,  // >= 1
   parameter int unsigned OAM_BYTES       = 160
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_wr,
   input  logic        cpu_rd,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_sel,
   output logic [15:0] dma_addr,
   output logic        dma_rd,
   input  logic [7:0]  dma_rdata,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_wdata,
   output logic        oam_we,
   output logic        dma_active
);

   localparam int unsigned PW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
   localparam int unsigned DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

   localparam logic [PW-1:0] PHASE_READ  = PW'(0);
   localparam logic [PW-1:0] PHASE_LATCH = PW'(1);
   localparam logic [PW-1:0] PHASE_WRITE = PW'(2);
   localparam logic [PW-1:0] PHASE_LAST  = PW'(CYCLES_PER_BYTE - 1);
   localparam logic [DW-1:0] DELAY_LAST  = DW'(START_DELAY - 1);
   localparam logic [7:0]    IDX_LAST    = 8'(OAM_BYTES - 1);

   dma_state_t    state_q, state_d;
   logic [7:0]    src_page_q, src_page_d;
   logic [7:0]    idx_q, idx_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [DW-1:0] delay_q, delay_d;
   logic [7:0]    data_q, data_d;

   logic reg_hit;
   logic trigger;
   logic last_byte_done;

   assign reg_hit        = (cpu_addr == DMA_REG_ADDR);
   assign trigger        = cpu_wr && reg_hit;
   assign last_byte_done = (phase_q == PHASE_LAST) && (idx_q == IDX_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a trigger restarts from START in any state.
   always_comb begin
      state_d = state_q;
      if (trigger) begin
         state_d = START;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            START:   if (delay_q == DELAY_LAST) state_d = XFER;
            XFER:    if (last_byte_done) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Page register, delay counter, phase/idx counter pair and data latch.
   always_ff @(posedge clk) begin
      if (reset) begin
         src_page_q <= 8'h00;
         idx_q      <= 8'h00;
         phase_q    <= '0;
         delay_q    <= '0;
         data_q     <= 8'h00;
      end else begin
         src_page_q <= src_page_d;
         idx_q      <= idx_d;
         phase_q    <= phase_d;
         delay_q    <= delay_d;
         data_q     <= data_d;
      end
   end

   // Counter and latch next-state values.
   always_comb begin
      src_page_d = trigger ? cpu_wdata : src_page_q;
      idx_d      = 8'h00;
      phase_d    = '0;
      delay_d    = '0;
      data_d     = data_q;
      if (!trigger) begin
         case (state_q)
            START: begin
               if (delay_q != DELAY_LAST) delay_d = delay_q + DW'(1);
            end
            XFER: begin
               if (phase_q == PHASE_LATCH) data_d = dma_rdata;
               if (phase_q == PHASE_LAST) begin
                  // idx never steps past IDX_LAST, so the source low byte cannot wrap.
                  idx_d = (idx_q == IDX_LAST) ? 8'h00 : idx_q + 8'd1;
               end else begin
                  idx_d   = idx_q;
                  phase_d = phase_q + PW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Bus outputs decoded from state and phase.
   always_comb begin
      dma_active = (state_q != IDLE);
      dma_rd     = 1'b0;
      dma_addr   = 16'h0000;
      oam_we     = 1'b0;
      oam_addr   = 8'h00;
      oam_wdata  = 8'h00;
      cpu_sel    = reg_hit && (cpu_rd || cpu_wr);
      cpu_rdata  = (reg_hit && cpu_rd) ? src_page_q : 8'h00;
      if (state_q == XFER) begin
         if (phase_q == PHASE_READ) begin
            dma_rd   = 1'b1;
            dma_addr = {eff_page(src_page_q), idx_q};
         end
         if (phase_q == PHASE_WRITE) begin
            oam_we    = 1'b1;
            oam_addr  = idx_q;
            oam_wdata = data_q;
         end
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: memory model on the source side, OAM image
// capture on the sink side, CPU register accesses driven from tasks.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_wr;
   logic        cpu_rd;
   logic [7:0]  cpu_rdata;
   logic        cpu_sel;
   logic [15:0] dma_addr;
   logic        dma_rd;
   logic [7:0]  dma_rdata = 8'h00;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wdata;
   logic        oam_we;
   logic        dma_active;

   oam_dma dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_wr     (cpu_wr),
      .cpu_rd     (cpu_rd),
      .cpu_rdata  (cpu_rdata),
      .cpu_sel    (cpu_sel),
      .dma_addr   (dma_addr),
      .dma_rd     (dma_rd),
      .dma_rdata  (dma_rdata),
      .oam_addr   (oam_addr),
      .oam_wdata  (oam_wdata),
      .oam_we     (oam_we),
      .dma_active (dma_active)
   );

   always #5 clk = ~clk;

   // System memory: read data appears the clock after dma_rd.
   logic [7:0] mem [0:65535];
   always @(posedge clk) if (dma_rd) dma_rdata <= mem[dma_addr];

   int checks   = 0;
   int failures = 0;

   // Observations, sampled on the falling edge.
   int         n_trig, overlap_cnt, active_cnt, drop_cnt, rd_cnt, rd_page_err;
   int         we_cnt, asc_err, first_rd_n, first_we_n, first_active_n;
   logic       prev_active;
   logic [7:0] exp_page;
   logic [7:0] oam_img [0:159];
   logic       s_active, s_rd, s_we, s_sel;
   logic [7:0] s_rdata, s_oaddr;
   logic [15:0] s_daddr;

   task automatic clear_obs();
      active_cnt = 0; drop_cnt = 0; rd_cnt = 0; rd_page_err = 0;
      we_cnt = 0; asc_err = 0; first_rd_n = -1; first_we_n = -1; first_active_n = -1;
      prev_active = 1'b0;
      for (int i = 0; i < 160; i++) oam_img[i] = 'x;
   endtask

   // One clock: observe at the falling edge, return just after the next rising edge.
   task automatic cycle();
      @(negedge clk);
      n_trig++;
      s_active = dma_active; s_rd = dma_rd; s_we = oam_we; s_sel = cpu_sel;
      s_rdata = cpu_rdata; s_oaddr = oam_addr; s_daddr = dma_addr;
      if (dma_rd && oam_we) overlap_cnt++;
      if (dma_active) begin
         active_cnt++;
         if (first_active_n < 0) first_active_n = n_trig;
      end
      if (prev_active && !dma_active) drop_cnt++;
      prev_active = dma_active;
      if (dma_rd) begin
         rd_cnt++;
         if (first_rd_n < 0) first_rd_n = n_trig;
         if (dma_addr[15:8] !== exp_page) rd_page_err++;
      end
      if (oam_we) begin
         if (first_we_n < 0) first_we_n = n_trig;
         if (oam_addr !== we_cnt[7:0]) asc_err++;
         if (oam_addr < 8'd160) oam_img[oam_addr] = oam_wdata;
         else asc_err++;
         we_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   // One-clock write strobe; n_trig restarts so the next sample is cycle 1.
   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
      cycle();
      cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
      n_trig = 0;
   endtask

   task automatic wait_idle(input int bound, output logic ok);
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         cycle();
         if (!s_active) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_we(input int target, input int bound, output logic ok);
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         cycle();
         if (we_cnt == target) begin ok = 1'b1; break; end
      end
   endtask

   task automatic check_overlap(input string name);
      checks++;
      if (overlap_cnt !== 0) begin
         failures++;
         $display("FAIL %s overlap: rd&we clocks=%0d expected 0", name, overlap_cnt);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_obs();
      repeat (3) cycle();
      checks++; if (s_active !== 1'b0) begin failures++; $display("FAIL reset_active: got %0b expected 0", s_active); end
      checks++; if (s_rd !== 1'b0 || s_we !== 1'b0) begin failures++; $display("FAIL reset_strobes: rd=%0b we=%0b expected 0 0", s_rd, s_we); end
      checks++; if (s_daddr !== 16'h0 || s_oaddr !== 8'h0) begin failures++; $display("FAIL reset_addr: dma=%0h oam=%0h expected 0 0", s_daddr, s_oaddr); end
      reset = 1'b0;
      cpu_rd = 1'b1; cpu_addr = 16'hFF46;
      cycle();
      checks++; if (s_rdata !== 8'h00 || s_sel !== 1'b1) begin failures++; $display("FAIL reset_readback: rdata=%0h sel=%0b expected 00 1", s_rdata, s_sel); end
      cpu_rd = 1'b0; cpu_addr = 16'h0000;
      check_overlap("reset");
   endtask

   task automatic test_full_transfer();
      logic ok;
      int bad;
      for (int i = 0; i < 256; i++) mem['hC100 + i] = 8'(i) ^ 8'h5A;
      clear_obs();
      cpu_write(16'hFF46, 8'hC1);
      exp_page = 8'hC1;
      checks++; if (s_sel !== 1'b1) begin failures++; $display("FAIL full_sel: got %0b expected 1", s_sel); end
      wait_idle(1000, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL full_timeout: idle=%0b expected 1", ok); end
      checks++; if (active_cnt !== 644) begin failures++; $display("FAIL full_active_len: got %0d expected 644", active_cnt); end
      checks++; if (first_active_n !== 1) begin failures++; $display("FAIL full_active_start: got %0d expected 1", first_active_n); end
      checks++; if (first_rd_n !== 5) begin failures++; $display("FAIL full_first_rd: got %0d expected 5", first_rd_n); end
      checks++; if (first_we_n !== 7) begin failures++; $display("FAIL full_first_we: got %0d expected 7", first_we_n); end
      checks++; if (we_cnt !== 160 || rd_cnt !== 160) begin failures++; $display("FAIL full_counts: we=%0d rd=%0d expected 160 160", we_cnt, rd_cnt); end
      checks++; if (asc_err !== 0 || rd_page_err !== 0) begin failures++; $display("FAIL full_order: asc_err=%0d page_err=%0d expected 0 0", asc_err, rd_page_err); end
      bad = 0;
      for (int i = 0; i < 160; i++) if (oam_img[i] !== (8'(i) ^ 8'h5A)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL full_data: bad bytes=%0d expected 0", bad); end
      check_overlap("full");
   endtask

   task automatic test_echo();
      logic ok;
      int bad;
      for (int i = 0; i < 256; i++) begin
         mem['hC200 + i] = 8'(i + 'h30);
         mem['hE200 + i] = 8'hEE;
      end
      clear_obs();
      cpu_write(16'hFF46, 8'hE2);
      exp_page = 8'hC2;
      wait_idle(1000, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL echo_timeout: idle=%0b expected 1", ok); end
      checks++; if (rd_page_err !== 0 || rd_cnt !== 160) begin failures++; $display("FAIL echo_src: page_err=%0d rd=%0d expected 0 160", rd_page_err, rd_cnt); end
      bad = 0;
      for (int i = 0; i < 160; i++) if (oam_img[i] !== 8'(i + 'h30)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL echo_data: bad bytes=%0d expected 0", bad); end
      cpu_rd = 1'b1; cpu_addr = 16'hFF46;
      cycle();
      checks++; if (s_rdata !== 8'hE2 || s_sel !== 1'b1) begin failures++; $display("FAIL echo_readback: rdata=%0h sel=%0b expected e2 1", s_rdata, s_sel); end
      cpu_rd = 1'b0; cpu_addr = 16'h0000;
      check_overlap("echo");
   endtask

   task automatic test_retrigger();
      logic ok;
      int bad;
      for (int i = 0; i < 256; i++) begin
         mem['hC000 + i] = 8'(i + 'h11);
         mem['hD000 + i] = ~8'(i);
      end
      clear_obs();
      cpu_write(16'hFF46, 8'hC0);
      exp_page = 8'hC0;
      wait_we(50, 1000, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL retrig_wait: reached=%0b expected 1", ok); end
      bad = 0;
      for (int i = 0; i < 50; i++) if (oam_img[i] !== 8'(i + 'h11)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL retrig_old_data: bad bytes=%0d expected 0", bad); end
      cpu_write(16'hFF46, 8'hD0);
      exp_page = 8'hD0;
      wait_idle(1000, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL retrig_timeout: idle=%0b expected 1", ok); end
      checks++; if (drop_cnt !== 1) begin failures++; $display("FAIL retrig_active_drops: got %0d expected 1", drop_cnt); end
      checks++; if (we_cnt !== 210 || rd_cnt !== 210) begin failures++; $display("FAIL retrig_counts: we=%0d rd=%0d expected 210 210", we_cnt, rd_cnt); end
      checks++; if (rd_page_err !== 0) begin failures++; $display("FAIL retrig_src: page_err=%0d expected 0", rd_page_err); end
      bad = 0;
      for (int i = 0; i < 160; i++) if (oam_img[i] !== ~8'(i)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL retrig_new_data: bad bytes=%0d expected 0", bad); end
      check_overlap("retrigger");
   endtask

   task automatic test_reset_mid();
      logic ok;
      clear_obs();
      cpu_write(16'hFF46, 8'hC1);
      exp_page = 8'hC1;
      wait_we(80, 1000, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstmid_wait: reached=%0b expected 1", ok); end
      reset = 1'b1;
      cycle();
      cycle();
      checks++; if (s_active !== 1'b0 || s_we !== 1'b0) begin failures++; $display("FAIL rstmid_abort: active=%0b we=%0b expected 0 0", s_active, s_we); end
      reset = 1'b0;
      repeat (20) cycle();
      checks++; if (we_cnt !== 80 || s_active !== 1'b0) begin failures++; $display("FAIL rstmid_quiet: we=%0d active=%0b expected 80 0", we_cnt, s_active); end
      cpu_rd = 1'b1; cpu_addr = 16'hFF46;
      cycle();
      checks++; if (s_rdata !== 8'h00) begin failures++; $display("FAIL rstmid_readback: rdata=%0h expected 00", s_rdata); end
      cpu_rd = 1'b0; cpu_addr = 16'h0000;
      check_overlap("reset_mid");
   endtask

   task automatic test_other_addr();
      logic ok;
      int bad;
      clear_obs();
      cpu_write(16'hFF46, 8'h9A);
      exp_page = 8'h9A;
      wait_idle(1000, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL other_timeout: idle=%0b expected 1", ok); end
      clear_obs();
      cpu_write(16'hFF47, 8'h12);
      checks++; if (s_sel !== 1'b0) begin failures++; $display("FAIL other_wr_sel: got %0b expected 0", s_sel); end
      repeat (10) cycle();
      cpu_rd = 1'b1; cpu_addr = 16'hFF46;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         if (s_sel !== 1'b1 || s_rdata !== 8'h9A) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL other_hold_rd: bad clocks=%0d expected 0 (sel=%0b rdata=%0h)", bad, s_sel, s_rdata); end
      cpu_addr = 16'hFF47;
      cycle();
      checks++; if (s_sel !== 1'b0 || s_rdata !== 8'h00) begin failures++; $display("FAIL other_rd_ff47: sel=%0b rdata=%0h expected 0 00", s_sel, s_rdata); end
      cpu_rd = 1'b0; cpu_addr = 16'h0000;
      checks++; if (active_cnt !== 0 || rd_cnt !== 0) begin failures++; $display("FAIL other_no_xfer: active=%0d rd=%0d expected 0 0", active_cnt, rd_cnt); end
      check_overlap("other_addr");
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      reset = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0;
      n_trig = 0; overlap_cnt = 0; exp_page = 8'h00;
      @(posedge clk);
      #1;
      test_reset();
      test_full_transfer();
      test_echo();
      test_retrigger();
      test_reset_mid();
      test_other_addr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/oam_dma.md
# oam_dma

Upstream feeder for the graphics peripheral's sprite attribute memory (OAM). The CPU writes a source page number to register 0xFF46. The block then copies 160 bytes from `{page, 8'h00}` into OAM addresses 0x00–0x9F, one byte per 4-clock machine cycle. During the copy it asserts `dma_active`, so bus arbitration can lock the CPU out of everything except HRAM.

## Interface
Parameters:
- `CYCLES_PER_BYTE`, default 4: clocks per transferred byte; must be ≥ 3.
- `START_DELAY`, default 4: clocks between the register write and the first source read.
- `OAM_BYTES`, default 160: bytes per transfer.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `cpu_addr` in 16: CPU bus address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_wr` in 1: CPU write strobe, one clock wide.
- `cpu_rd` in 1: CPU read strobe.
- `cpu_rdata` out 8: readback of 0xFF46; driven only when `cpu_rd` is high and the address matches, else 8'h00.
- `cpu_sel` out 1: high when this block claims the current CPU access.
- `dma_addr` out 16: source address to system memory.
- `dma_rd` out 1: source read strobe.
- `dma_rdata` in 8: source data, valid the clock after `dma_rd`.
- `oam_addr` out 8: OAM write address.
- `oam_wdata` out 8: OAM write data.
- `oam_we` out 1: OAM write strobe, one clock wide.
- `dma_active` out 1: a transfer is in progress (START or XFER).

## Operation
- Trigger: `cpu_wr` high with `cpu_addr == 16'hFF46` latches `cpu_wdata` into `src_page`.
  - `cpu_rdata` returns `src_page`.
  - Reset value of `src_page` is 8'h00.
- Source remap: a `src_page` of 0xE0–0xFF is used as `src_page & 8'hDF` (echo RAM maps to WRAM). The register readback keeps the unmodified value.
- States:
  - IDLE: no transfer. Leaves on a trigger.
  - START: counts `START_DELAY` clocks.
  - XFER: steps the byte index 0..`OAM_BYTES`-1, with a phase counter 0..`CYCLES_PER_BYTE`-1.
  - Transitions: IDLE→START on trigger; START→XFER when the delay expires; XFER→IDLE after the last byte's final phase.
- Per byte, in XFER:
  - Phase 0: `dma_rd`=1 and `dma_addr={eff_page, idx}`.
  - Phase 1: latch `dma_rdata` into the data register.
  - Phase 2: `oam_we`=1, `oam_addr`=idx, `oam_wdata`=latched data.
  - Remaining phases: idle. The last phase increments idx.
- Retrigger: a trigger in START or XFER restarts immediately.
  - The new page is latched, idx and phase clear, and the state goes to START.
  - A write strobe already scheduled for the current clock is still issued; nothing further comes from the old page.
- Writes to other addresses are ignored.
- `cpu_sel` asserts for reads or writes at 0xFF46 in any state.

## Timing
- Reset values: all outputs 0, state IDLE, idx 0, phase 0, `src_page` 8'h00.
  - Reset mid-transfer aborts within the same clock edge; no further `oam_we`.
- Trigger write at clock edge T:
  - `dma_active`=1 from T+1.
  - First `dma_rd` at T+1+`START_DELAY`.
  - First `oam_we` two clocks after that.
- Full transfer with defaults: `dma_active` stays high for 4 + 160×4 = 644 clocks, then drops in the clock after byte 159's phase 3.
- `oam_we` pulses exactly `OAM_BYTES` times per uninterrupted transfer, with addresses strictly ascending 0x00→0x9F.
- `dma_rd` and `oam_we` are never high in the same clock.
- Arithmetic:
  - idx is 8 bits and never exceeds `OAM_BYTES`-1, so the address low byte never wraps.
  - The phase counter is `$clog2(CYCLES_PER_BYTE)` bits.
- A trigger and reset in the same clock: reset wins.

## Structure
- Shared package `dma_types` holds:
  - enum `dma_state_t` {IDLE, START, XFER};
  - `localparam DMA_REG_ADDR = 16'hFF46`;
  - `OAM_BASE = 16'hFE00`, used by the bus arbiter;
  - the echo remap constants.
- Single module, no sub-module. The phase/idx counter pair is internal.
- The module gets a `BaseTest` subclass `oam_dma_tb` added to the test-runner queue, driving the CPU side and modelling memory as an array.

## Test plan
- Reset, then write 8'hC1 to 0xFF46 with memory[0xC100+i]=i^8'h5A → 160 OAM writes, OAM[i]=i^8'h5A, `dma_active` high for 644 clocks, first `oam_we` at T+7.
- Write 8'hE2 → source reads hit 0xC200–0xC29F; a read of 0xFF46 returns 8'hE2.
- Write 8'hC0, then 8'hD0 at byte 50 → OAM[0..49] come from 0xC0xx, OAM[0..159] end up from 0xD0xx, `dma_active` stays high throughout.
- Assert `reset` at byte 80 → `oam_we` stops, `dma_active`=0 the next clock, and 0xFF46 reads 8'h00.
- Write 8'h12 to 0xFF47, and hold `cpu_rd` at 0xFF46 while idle → no transfer starts, `cpu_sel`=1 only for 0xFF46, `cpu_rdata` equals the last value written.
- Throughout every scenario, check that `dma_rd` and `oam_we` are never high in the same clock.
